// File: rtl/demux_1x4_buffered.sv
// demux_1x4_buffered: routes one WIDTH-bit valid/ready stream to one of four
// independent output channels. Each channel has its own DEPTH-entry FIFO, so
// a stalled consumer only back-pressures traffic addressed to its own channel.
module demux_1x4_buffered #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*CW-1:0]    out_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] mem_d    [4][DEPTH];
    logic [PW-1:0]    rd_ptr_q [4];
    logic [PW-1:0]    rd_ptr_d [4];
    logic [PW-1:0]    wr_ptr_q [4];
    logic [PW-1:0]    wr_ptr_d [4];
    logic [CW-1:0]    count_q  [4];
    logic [CW-1:0]    count_d  [4];

    logic [3:0] full;
    logic [3:0] push;
    logic [3:0] pop;

    // Handshake decode and next-state for every channel FIFO.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full     = '0;
        push     = '0;
        pop      = '0;

        for (int unsigned ch = 0; ch < 4; ch++) begin
            full[ch] = (count_q[ch] == CW'(DEPTH));
        end

        // A full channel refuses even if it is popping this cycle: no bypass.
        in_ready = !full[in_sel] && !flush;

        for (int unsigned ch = 0; ch < 4; ch++) begin
            push[ch] = in_valid && in_ready && (in_sel == 2'(ch));
            pop[ch]  = (count_q[ch] != '0) && out_ready[ch];

            if (flush) begin
                rd_ptr_d[ch] = '0;
                wr_ptr_d[ch] = '0;
                count_d[ch]  = '0;
            end else begin
                if (push[ch]) begin
                    mem_d[ch][wr_ptr_q[ch]] = in_data;
                    wr_ptr_d[ch] = wr_ptr_q[ch] + PW'(1);
                end
                if (pop[ch]) begin
                    rd_ptr_d[ch] = rd_ptr_q[ch] + PW'(1);
                end
                if (push[ch] && !pop[ch]) begin
                    count_d[ch] = count_q[ch] + CW'(1);
                end else if (pop[ch] && !push[ch]) begin
                    count_d[ch] = count_q[ch] - CW'(1);
                end
            end
        end
    end

    // Output view of the registered FIFO state; data is forced to 0 when empty.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        out_count = '0;
        for (int unsigned ch = 0; ch < 4; ch++) begin
            out_valid[ch]            = (count_q[ch] != '0);
            out_count[ch*CW +: CW]   = count_q[ch];
            if (count_q[ch] != '0) begin
                out_data[ch*WIDTH +: WIDTH] = mem_q[ch][rd_ptr_q[ch]];
            end
        end
    end

    // FIFO state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned ch = 0; ch < 4; ch++) begin
                rd_ptr_q[ch] <= '0;
                wr_ptr_q[ch] <= '0;
                count_q[ch]  <= '0;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    mem_q[ch][e] <= '0;
                end
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_demux_1x4_buffered.sv
// tb_demux_1x4_buffered: directed checks of routing, backpressure, push+pop,
// flush and reset, followed by a random run against four reference queues.
module tb_demux_1x4_buffered;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CW-1:0]    out_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] q [4][$];

    demux_1x4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 4'b0000;
    endtask

    task automatic push(input logic [1:0] sel, input logic [WIDTH-1:0] data);
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] data_of(input int ch);
        return out_data[ch*WIDTH +: WIDTH];
    endfunction

    function automatic logic [CW-1:0] count_of(input int ch);
        return out_count[ch*CW +: CW];
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'h0);
        check("rst_count", 128'(out_count), 128'h0);
        check("rst_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 128'(in_ready), 128'h1);

        // Routing: one word into each channel.
        for (int i = 0; i < 4; i++) push(2'(i), 32'hA0 + 32'(i));
        check("route_valid", 128'(out_valid), 128'hF);
        check("route_count", 128'(out_count), 128'h55);
        for (int i = 0; i < 4; i++) check($sformatf("route_data%0d", i), 128'(data_of(i)), 128'hA0 + 128'(i));

        // Flush with a concurrent push: everything cleared, push dropped.
        flush    = 1'b1;
        in_sel   = 2'd1;
        in_data  = 32'hDEAD;
        in_valid = 1'b1;
        #1;
        check("flush_in_ready", 128'(in_ready), 128'h0);
        check("flush_hold_valid", 128'(out_valid), 128'hF);
        step();
        idle();
        check("flush_valid", 128'(out_valid), 128'h0);
        check("flush_count", 128'(out_count), 128'h0);
        check("flush_data", out_data, 128'h0);
        step();
        check("flush_no_store", 128'(out_valid), 128'h0);

        // Full / backpressure on ch2.
        push(2'd2, 32'h11);
        push(2'd2, 32'h22);
        in_sel   = 2'd2;
        in_data  = 32'h33;
        in_valid = 1'b1;
        #1;
        check("full_in_ready", 128'(in_ready), 128'h0);
        in_sel = 2'd3;
        #1;
        check("other_ch_ready", 128'(in_ready), 128'h1);
        in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        check("full_count", 128'(count_of(2)), 128'h2);
        check("full_head", 128'(data_of(2)), 128'h11);
        out_ready = 4'b0100;
        step();
        check("drain_head2", 128'(data_of(2)), 128'h22);
        check("drain_count1", 128'(count_of(2)), 128'h1);
        step();
        check("drain_empty", 128'(out_valid), 128'h0);
        idle();

        // Simultaneous push+pop on ch0; ch1 must stay untouched.
        push(2'd0, 32'h5);
        push(2'd1, 32'h7);
        in_sel    = 2'd0;
        in_data   = 32'h6;
        in_valid  = 1'b1;
        out_ready = 4'b0001;
        #1;
        check("pp_in_ready", 128'(in_ready), 128'h1);
        step();
        idle();
        check("pp_count0", 128'(count_of(0)), 128'h1);
        check("pp_head0", 128'(data_of(0)), 128'h6);
        check("pp_count1", 128'(count_of(1)), 128'h1);
        check("pp_head1", 128'(data_of(1)), 128'h7);
        out_ready = 4'b1111;
        step();
        idle();
        check("pp_drained", 128'(out_valid), 128'h0);

        // Push into empty ch3 with out_ready high: no pop occurs.
        in_sel    = 2'd3;
        in_data   = 32'h99;
        in_valid  = 1'b1;
        out_ready = 4'b1000;
        step();
        idle();
        check("empty_pp_count", 128'(count_of(3)), 128'h1);
        check("empty_pp_head", 128'(data_of(3)), 128'h99);
        out_ready = 4'b1000;
        step();
        idle();

        // Reset mid-stream with ch1 full.
        push(2'd1, 32'hB0);
        push(2'd1, 32'hB1);
        check("pre_rst_count", 128'(count_of(1)), 128'h2);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'h0);
        check("async_rst_count", 128'(out_count), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 128'(in_ready), 128'h1);
        check("post_rst_valid", 128'(out_valid), 128'h0);

        // Random traffic against per-channel reference queues.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic             exp_ready;
            logic [3:0]       exp_valid;
            logic [127:0]     exp_data;
            logic [7:0]       exp_count;
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 4'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 99) < 2);
            #1;
            exp_ready = (q[in_sel].size() < DEPTH) && !flush;
            exp_valid = '0;
            exp_data  = '0;
            exp_count = '0;
            for (int ch = 0; ch < 4; ch++) begin
                exp_count[ch*CW +: CW] = CW'(q[ch].size());
                if (q[ch].size() != 0) begin
                    exp_valid[ch] = 1'b1;
                    exp_data[ch*WIDTH +: WIDTH] = q[ch][0];
                end
            end
            check("rnd_in_ready", 128'(in_ready), 128'(exp_ready));
            check("rnd_valid", 128'(out_valid), 128'(exp_valid));
            check("rnd_data", out_data, exp_data);
            check("rnd_count", 128'(out_count), 128'(exp_count));
            if (flush) begin
                for (int ch = 0; ch < 4; ch++) q[ch].delete();
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (q[ch].size() != 0 && out_ready[ch]) void'(q[ch].pop_front());
                end
                if (in_valid && exp_ready) q[in_sel].push_back(in_data);
            end
            step();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
